// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and funct3 decode for dmem_ctrl.
// DMEM_CTRL_RMW_EN enables sub-word stores via read-modify-write.
package dmem_ctrl_pkg;
`ifdef DMEM_CTRL_RMW_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
  typedef enum logic {CORE, DBG} req_id_t;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  function automatic logic f3_bad(input logic we, input logic [2:0] f3);
`ifdef DMEM_CTRL_RMW_EN
    return we ? (f3 > SW) : (f3 == 3'b011 || (f3[2] && f3[1:0] != 2'b00));
`else
    return we ? (f3 != SW) : (f3 == 3'b011 || (f3[2] && f3[1:0] != 2'b00));
`endif
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b10 && a != 2'b00) || (f3[1:0] == 2'b01 && a[0]);
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: core, debug and data-memory signals of dmem_ctrl.
interface dmem_ctrl_if #(parameter int DM_ADDRESS = 9, parameter int DATA_W = 32);
  logic c_req, c_we, c_gnt, c_done, c_err;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic [2:0] c_funct3;
  logic d_req, d_we, d_gnt, d_done, d_err;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [2:0] d_funct3;
  logic m_MemRead, m_MemWrite;
  logic [DM_ADDRESS-1:0] m_a;
  logic [DATA_W-1:0] m_wd, m_rd;
  logic [2:0] m_Funct3;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3, d_req, d_we, d_addr, d_wdata, d_funct3, m_rd,
    output c_gnt, c_done, c_err, c_rdata, d_gnt, d_done, d_err, d_rdata,
           m_MemRead, m_MemWrite, m_a, m_wd, m_Funct3
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3, d_req, d_we, d_addr, d_wdata, d_funct3, m_rd,
    input  c_gnt, c_done, c_err, c_rdata, d_gnt, d_done, d_err, d_rdata,
           m_MemRead, m_MemWrite, m_a, m_wd, m_Funct3
  );
endinterface

// File: rtl/dmem_store_merge.sv
// dmem_store_merge: splice a store byte/halfword into a word read from memory.
module dmem_store_merge #(parameter int DATA_W = 32) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [15:0]       wdata,
  input  logic [1:0]        lane,
  input  logic              half,
  output logic [DATA_W-1:0] merged
);
  always_comb begin
    merged = old_word;
    if (half) merged[{lane[1], 4'd0} +: 16] = wdata;
    else merged[{lane, 3'd0} +: 8] = wdata[7:0];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin arbiter of core/debug ports onto one data memory.
// DMEM_CTRL_RMW_EN adds read-modify-write for SB/SH; otherwise they are errors.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic        clk,
  input logic        rst_n,
  dmem_ctrl_if.slave bus
);
  state_t state, state_nx;
  req_id_t ptr, id;
  logic we_q;
  logic [DM_ADDRESS-1:0] addr_q, addr_w;
  logic [DATA_W-1:0] wdata_q, c_rdata_q, d_rdata_q, merged;
  logic [2:0] f3_q;
  logic pick_d, any, bad, sub, acc, resp, rd, wr, rmw;
  assign any = bus.c_req || bus.d_req;
  assign pick_d = bus.d_req && (!bus.c_req || ptr == DBG);
  assign acc = state == ACCESS;
  assign resp = state == RESP;
  assign bad = f3_bad(we_q, f3_q) || misaligned(f3_q, addr_q[1:0]);
  assign addr_w = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign rd = acc && !bad && (!we_q || sub);
  assign wr = acc && !bad && we_q && !sub;
`ifdef DMEM_CTRL_RMW_EN
  logic [DATA_W-1:0] word_q;
  assign sub = we_q && f3_q != SW;
  assign rmw = state == RMW_WR;
  dmem_store_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word(word_q),
    .wdata   (wdata_q[15:0]),
    .lane    (addr_q[1:0]),
    .half    (f3_q == SH),
    .merged  (merged)
  );
`else
  assign sub = 1'b0;
  assign rmw = 1'b0;
  assign merged = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= CORE;
      id <= CORE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef DMEM_CTRL_RMW_EN
      word_q <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        id <= pick_d ? DBG : CORE;
        ptr <= pick_d ? CORE : DBG;
        we_q <= pick_d ? bus.d_we : bus.c_we;
        addr_q <= pick_d ? bus.d_addr : bus.c_addr;
        wdata_q <= pick_d ? bus.d_wdata : bus.c_wdata;
        f3_q <= pick_d ? bus.d_funct3 : bus.c_funct3;
      end
      if (rd && !sub && id == CORE) c_rdata_q <= bus.m_rd;
      if (rd && !sub && id == DBG) d_rdata_q <= bus.m_rd;
`ifdef DMEM_CTRL_RMW_EN
      if (rd) word_q <= bus.m_rd;
`endif
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = any ? ACCESS : IDLE;
`ifdef DMEM_CTRL_RMW_EN
      ACCESS: state_nx = (sub && !bad) ? RMW_WR : RESP;
      RMW_WR: state_nx = RESP;
`else
      ACCESS: state_nx = RESP;
`endif
      default: state_nx = IDLE;
    endcase
  end
  assign bus.c_gnt = acc && id == CORE;
  assign bus.d_gnt = acc && id == DBG;
  assign bus.c_done = resp && id == CORE;
  assign bus.d_done = resp && id == DBG;
  assign bus.c_err = resp && id == CORE && bad;
  assign bus.d_err = resp && id == DBG && bad;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  // sub-word stores read and write the whole aligned word
  assign bus.m_MemRead = rd;
  assign bus.m_MemWrite = wr || rmw;
  assign bus.m_a = ((rd && sub) || rmw) ? addr_w : (rd || wr) ? addr_q : '0;
  assign bus.m_wd = wr ? wdata_q : rmw ? merged : '0;
  assign bus.m_Funct3 = ((rd && sub) || rmw) ? SW : (rd || wr) ? f3_q : 3'b000;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors with a scoreboard of expected grants,
// memory strobes and completions checked by a negedge monitor.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;
  localparam int AW = 9, DW = 32;
  typedef struct { bit p; int cyc; } gnt_t;
  typedef struct { bit p; bit err; bit k; logic [DW-1:0] rd; int cyc; } done_t;
  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] wd; logic [2:0] f3; int cyc; } mop_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] mrd = '0;
  int cyc = 0, checks = 0, fails = 0;
  gnt_t gq[$], gg;
  done_t dq[$], dd;
  mop_t mq[$], mm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_ctrl_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus();
  dmem_ctrl #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.m_rd = mrd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic eg(input bit p, input int c);
    gq.push_back('{p, c});
  endtask
  task automatic ed(input bit p, input bit e, input bit k, input logic [DW-1:0] r, input int c);
    dq.push_back('{p, e, k, r, c});
  endtask
  task automatic em(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [2:0] f3, input int c);
    mq.push_back('{we, a, wd, f3, c});
  endtask

  task automatic issue(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [2:0] f3);
    bit got = 0;
    if (p) begin
      bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_funct3 = f3; bus.d_req = 1'b1;
    end else begin
      bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd; bus.c_funct3 = f3; bus.c_req = 1'b1;
    end
    repeat (20) begin
      @(negedge clk);
      if (p ? bus.d_gnt : bus.c_gnt) begin
        got = 1;
        break;
      end
    end
    chk(p ? "d_gnt_seen" : "c_gnt_seen", 64'(got), 1);
    if (p) bus.d_req = 1'b0;
    else bus.c_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (gq.size() + dq.size() + mq.size()) != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 64'(gq.size() + dq.size() + mq.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // both ports store at once: core wins from a core-favouring pointer
  task automatic contend(input logic [AW-1:0] ca, input logic [DW-1:0] cw, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    int n = cyc;
    eg(0, n + 1); eg(1, n + 4);
    em(1, ca, cw, SW, n + 1); em(1, da, dw, SW, n + 4);
    ed(0, 0, 0, '0, n + 2); ed(1, 0, 0, '0, n + 5);
    fork
      issue(0, 1, ca, cw, SW);
      issue(1, 1, da, dw, SW);
    join
    drain();
  endtask

  always @(negedge clk) begin
    chk("rw_excl", 64'(bus.m_MemRead & bus.m_MemWrite), 0);
    chk("err_no_done", {bus.c_err & ~bus.c_done, bus.d_err & ~bus.d_done}, 0);
    if (!(bus.m_MemRead || bus.m_MemWrite)) chk("m_idle", {bus.m_a, bus.m_Funct3, bus.m_wd}, 0);
    else if (mq.size() == 0) chk("mop_unexpected", {bus.m_MemRead, bus.m_MemWrite}, 0);
    else begin
      mm = mq.pop_front();
      chk("mop_we", 64'(bus.m_MemWrite), 64'(mm.we));
      chk("mop_addr", bus.m_a, mm.a);
      chk("mop_f3", bus.m_Funct3, mm.f3);
      if (mm.we) chk("mop_wd", bus.m_wd, mm.wd);
      chk("mop_cycle", cyc, mm.cyc);
    end
    if (bus.c_gnt || bus.d_gnt) begin
      if (gq.size() == 0) chk("gnt_unexpected", {bus.c_gnt, bus.d_gnt}, 0);
      else begin
        gg = gq.pop_front();
        chk("gnt_port", {bus.c_gnt, bus.d_gnt}, gg.p ? 2'b01 : 2'b10);
        chk("gnt_cycle", cyc, gg.cyc);
      end
    end
    if (bus.c_done || bus.d_done) begin
      if (dq.size() == 0) chk("done_unexpected", {bus.c_done, bus.d_done}, 0);
      else begin
        dd = dq.pop_front();
        chk("done_port", {bus.c_done, bus.d_done}, dd.p ? 2'b01 : 2'b10);
        chk("done_err", 64'(dd.p ? bus.d_err : bus.c_err), 64'(dd.err));
        if (dd.k) chk("done_rdata", dd.p ? bus.d_rdata : bus.c_rdata, dd.rd);
        chk("done_cycle", cyc, dd.cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_funct3 = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {bus.c_gnt, bus.c_done, bus.c_err, bus.d_gnt, bus.d_done, bus.d_err, bus.m_MemRead, bus.m_MemWrite}, 0);
    chk("rst_rdata", {bus.c_rdata, bus.d_rdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    contend(9'h040, 32'h1111_0001, 9'h044, 32'h2222_0002);
    // core LW
    mrd = 32'hDEAD_BEEF; n = cyc;
    eg(0, n + 1); em(0, 9'h010, '0, LW, n + 1); ed(0, 0, 1, 32'hDEAD_BEEF, n + 2);
    issue(0, 0, 9'h010, '0, LW);
    drain();
    // debug SB into byte lane 1
    mrd = 32'h1122_3344; n = cyc;
    eg(1, n + 1);
`ifdef DMEM_CTRL_RMW_EN
    em(0, 9'h004, '0, SW, n + 1); em(1, 9'h004, 32'h1122_AA44, SW, n + 2); ed(1, 0, 0, '0, n + 3);
`else
    ed(1, 1, 0, '0, n + 2);
`endif
    issue(1, 1, 9'h005, 32'h0000_00AA, SB);
    drain();
    // core SW misaligned
    n = cyc;
    eg(0, n + 1); ed(0, 1, 0, '0, n + 2);
    issue(0, 1, 9'h006, 32'h5555_5555, SW);
    drain();
    chk("c_rdata_hold", bus.c_rdata, 32'hDEAD_BEEF);
    // both load, debug favoured after last core grant
    mrd = 32'h0BAD_CAFE; n = cyc;
    eg(1, n + 1); eg(0, n + 4);
    em(0, 9'h023, '0, LBU, n + 1); em(0, 9'h012, '0, LH, n + 4);
    ed(1, 0, 1, 32'h0BAD_CAFE, n + 2); ed(0, 0, 1, 32'h0BAD_CAFE, n + 5);
    fork
      issue(0, 0, 9'h012, '0, LH);
      issue(1, 0, 9'h023, '0, LBU);
    join
    drain();
    // illegal funct3 and misaligned LW
    n = cyc;
    eg(0, n + 1); ed(0, 1, 0, '0, n + 2);
    issue(0, 0, 9'h000, '0, 3'b011);
    drain();
    n = cyc;
    eg(1, n + 1); ed(1, 1, 0, '0, n + 2);
    issue(1, 0, 9'h022, '0, LW);
    drain();
    // core SH upper half, debug SB lane 3
    mrd = 32'hCAFE_F00D; n = cyc;
    eg(0, n + 1);
`ifdef DMEM_CTRL_RMW_EN
    em(0, 9'h000, '0, SW, n + 1); em(1, 9'h000, 32'h5566_F00D, SW, n + 2); ed(0, 0, 0, '0, n + 3);
`else
    ed(0, 1, 0, '0, n + 2);
`endif
    issue(0, 1, 9'h002, 32'h1234_5566, SH);
    drain();
    n = cyc;
    eg(1, n + 1);
`ifdef DMEM_CTRL_RMW_EN
    em(0, 9'h008, '0, SW, n + 1); em(1, 9'h008, 32'h77FE_F00D, SW, n + 2); ed(1, 0, 0, '0, n + 3);
`else
    ed(1, 1, 0, '0, n + 2);
`endif
    issue(1, 1, 9'h00B, 32'h0000_0077, SB);
    drain();
    // reset mid-transaction: abandoned, no write, no done
    n = cyc;
    eg(0, n + 1);
`ifdef DMEM_CTRL_RMW_EN
    em(0, 9'h004, '0, SW, n + 1);
    issue(0, 1, 9'h005, 32'h0000_00EE, SB);
`else
    em(0, 9'h010, '0, LW, n + 1);
    issue(0, 0, 9'h010, '0, LW);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {bus.c_gnt, bus.c_done, bus.c_err, bus.d_gnt, bus.d_done, bus.d_err, bus.m_MemRead, bus.m_MemWrite}, 0);
    chk("rst_mid_m", {bus.m_a, bus.m_Funct3, bus.m_wd}, 0);
    chk("rst_mid_rdata", {bus.c_rdata, bus.d_rdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain();
    // pointer back on core after reset
    contend(9'h080, 32'hA5A5_0003, 9'h084, 32'h5A5A_0004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
